// File: rtl/fanin_merge_pkg.sv
// Shared constants and types for the fan-in round-robin merge.
package fanin_merge_pkg;

  localparam int unsigned NUM_IN_DEF = 4;
  localparam int unsigned DATA_W_DEF = 17;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef logic [$clog2(NUM_IN_DEF)-1:0] idx_t;
  typedef logic [1:0]                    fifo_cnt_t;

  // The top payload bit carries the stream last/stop flag.
  function automatic int unsigned last_bit(input int unsigned data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, cyclic ascending.
module rr_arbiter #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic              valid_o
);

  int unsigned idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = (k + 32'(ptr_i)) % NUM_IN;
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDX_W'(idx);
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fanin_merge_rr.sv
// Merges NUM_IN valid/data streams into one through a round-robin arbiter and a 2-entry skid FIFO.
// Optional FANIN_MERGE_LAST_LOCK_EN holds the grant on one source until its last-flagged beat.
module fanin_merge_rr
  import fanin_merge_pkg::*;
#(
  parameter int unsigned NUM_IN     = NUM_IN_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = fanin_merge_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          in_en,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  output logic [NUM_IN-1:0]          in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(NUM_IN)-1:0]  grant_idx
);

  localparam int unsigned IdxW    = $clog2(NUM_IN);
  localparam int unsigned LastBit = last_bit(DATA_W);

  fifo_cnt_t         count_q, count_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   gidx_q, gidx_d;

  logic [NUM_IN-1:0] req, req_arb, gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_valid, can_push, push, pop;
  logic [DATA_W-1:0] push_data;

  assign req = in_en & in_valid;

`ifdef FANIN_MERGE_LAST_LOCK_EN
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_act;

  // A holder that loses its enable no longer masks the others.
  assign lock_act = lock_q & in_en[lock_idx_q];
  assign req_arb  = lock_act ? (req & (NUM_IN'(1) << lock_idx_q)) : req;
`else
  assign req_arb  = req;
`endif

  rr_arbiter #(
    .NUM_IN(NUM_IN),
    .IDX_W (IdxW)
  ) u_arb (
    .req_i    (req_arb),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .valid_o  (gnt_valid)
  );

  // Push is blocked at full even if a pop happens, keeping in_ready off the out_ready path.
  assign can_push  = (count_q != fifo_cnt_t'(FIFO_DEPTH)) & ~reset;
  assign in_ready  = gnt & {NUM_IN{can_push}};
  assign push      = gnt_valid & can_push;
  assign push_data = in_data[gnt_idx*DATA_W +: DATA_W];
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[0];
  assign pop       = out_valid & out_ready;
  assign grant_idx = gidx_q;

  // Entries beyond count are kept at zero so the head reads zero when empty.
  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    if (push) begin
      ptr_d  = (gnt_idx == IdxW'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
      gidx_d = gnt_idx;
    end
    unique case ({push, pop})
      2'b10: begin
        if (count_q == '0) mem_d[0] = push_data;
        else               mem_d[1] = push_data;
        count_d = count_q + 1'b1;
      end
      2'b01: begin
        mem_d[0] = mem_q[1];
        mem_d[1] = '0;
        count_d  = count_q - 1'b1;
      end
      2'b11: mem_d[0] = push_data;
      default: ;
    endcase
  end

`ifdef FANIN_MERGE_LAST_LOCK_EN
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (push) begin
      lock_d     = ~push_data[LastBit];
      lock_idx_d = gnt_idx;
    end else if (lock_q && !in_en[lock_idx_q]) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      mem_q   <= '{default: '0};
      ptr_q   <= '0;
      gidx_q  <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

endmodule
